// File: rtl/shift_arbiter.sv
// Round-robin arbiter that shares one external combinational shifter between
// two requesters; one operation in flight, result held until its owner takes it.
module shift_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_res,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_res,
  output logic             sh_opcode,
  output logic [WIDTH-1:0] sh_a,
  output logic [WIDTH-1:0] sh_b,
  input  logic [WIDTH-1:0] sh_res
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   owner;
  logic   grant_any;
  logic   grant_id;
  logic   accept;
  logic   owner_ready;

  // Round-robin pick: on contention the requester not granted last time wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    grant_any = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign accept      = (state == IDLE) && grant_any;
  assign owner_ready = owner ? resp1_ready : resp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (owner_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE && grant_any) begin
      req0_ready = ~grant_id;
      req1_ready = grant_id;
    end
  end

  // Operand registers hold their last values between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these are plain registers whose reset values are visible on ports, so they are reset.
      last_grant <= 1'b1;
      owner      <= 1'b0;
      sh_opcode  <= 1'b0;
      sh_a       <= '0;
      sh_b       <= '0;
    end else if (accept) begin
      owner      <= grant_id;
      last_grant <= grant_id;
      sh_opcode  <= grant_id ? req1_opcode : req0_opcode;
      sh_a       <= grant_id ? req1_a      : req0_a;
      sh_b       <= grant_id ? req1_b      : req0_b;
    end
  end

  // Result is captured at the end of ISSUE and held until the owner accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp0_res   <= '0;
      resp1_res   <= '0;
    end else if (state == ISSUE) begin
      if (owner) begin
        resp1_valid <= 1'b1;
        resp1_res   <= sh_res;
      end else begin
        resp0_valid <= 1'b1;
        resp0_res   <= sh_res;
      end
    end else if (state == RESP && owner_ready) begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
    end
  end

endmodule
